// File: rtl/life_evolve_engine.sv
// Game-of-Life evolution core: double-buffered cell map with programmable birth/survive rules, one row per cycle.
// start -> done after MAP_HEIGHT+1 cycles; edits and commands are ignored while busy, reads are always served.
module life_evolve_engine #(
  parameter int MAP_WIDTH  = 8,
  parameter int MAP_HEIGHT = 8,
  parameter int ADDR_W     = 8,
  parameter int GEN_W      = 16,
  parameter int POP_W      = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              clear,
  input  logic              wrap_mode,
  input  logic [8:0]        birth_mask,
  input  logic [8:0]        survive_mask,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] wAddrR,
  input  logic [ADDR_W-1:0] wAddrC,
  input  logic              write_data,
  input  logic [ADDR_W-1:0] rAddrR,
  input  logic [ADDR_W-1:0] rAddrC,
  output logic              read_data,
  output logic              busy,
  output logic              done,
  output logic [GEN_W-1:0]  generation,
  output logic [POP_W-1:0]  population
);

  localparam int ROW_W = $clog2(MAP_HEIGHT);
  localparam int COL_W = $clog2(MAP_WIDTH);
  localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(MAP_HEIGHT - 1);
  localparam logic [ADDR_W-1:0] H_LIM    = ADDR_W'(MAP_HEIGHT);
  localparam logic [ADDR_W-1:0] W_LIM    = ADDR_W'(MAP_WIDTH);

  typedef enum logic [1:0] {IDLE, EVOLVE, FLIP} state_t;

  state_t state, state_nxt;

  logic [MAP_HEIGHT-1:0][MAP_WIDTH-1:0] bank [2];
  logic                 act;
  logic [ROW_W-1:0]     row;
  logic [POP_W-1:0]     acc;
  logic                 wrap_lat;
  logic [8:0]           birth_lat;
  logic [8:0]           survive_lat;

  logic [MAP_WIDTH-1:0] up, mid, dn;
  logic [MAP_WIDTH-1:0] up_e, up_w, mid_e, mid_w, dn_e, dn_w;
  logic [MAP_WIDTH-1:0] row_next;
  logic [POP_W-1:0]     row_pop;
  logic                 wr_hit, rd_hit, cell_old;

  // Bit c of the result is the neighbour at column c+1 (east) or c-1 (west); w fills the map edge.
  function automatic logic [MAP_WIDTH-1:0] east(input logic [MAP_WIDTH-1:0] x, input logic w);
    return {w & x[0], x[MAP_WIDTH-1:1]};
  endfunction

  function automatic logic [MAP_WIDTH-1:0] west(input logic [MAP_WIDTH-1:0] x, input logic w);
    return {x[MAP_WIDTH-2:0], w & x[MAP_WIDTH-1]};
  endfunction

  assign wr_hit   = write_en && (wAddrR < H_LIM) && (wAddrC < W_LIM);
  assign rd_hit   = (rAddrR < H_LIM) && (rAddrC < W_LIM);
  assign cell_old = bank[act][wAddrR[ROW_W-1:0]][wAddrC[COL_W-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!clear && start) state_nxt = EVOLVE;
      EVOLVE:  if (row == LAST_ROW) state_nxt = FLIP;
      FLIP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == FLIP);

  // Vertical neighbours of the row being computed; missing rows read as dead unless wrapping.
  always_comb begin
    mid = bank[act][row];
    up  = '0;
    dn  = '0;
    if (row != '0) begin
      up = bank[act][row - 1'b1];
    end else if (wrap_lat) begin
      up = bank[act][MAP_HEIGHT-1];
    end
    if (row != LAST_ROW) begin
      dn = bank[act][row + 1'b1];
    end else if (wrap_lat) begin
      dn = bank[act][0];
    end
  end

  assign up_e  = east(up,  wrap_lat);
  assign up_w  = west(up,  wrap_lat);
  assign mid_e = east(mid, wrap_lat);
  assign mid_w = west(mid, wrap_lat);
  assign dn_e  = east(dn,  wrap_lat);
  assign dn_w  = west(dn,  wrap_lat);

  always_comb begin
    logic [3:0] n;
    n        = '0;
    row_next = '0;
    row_pop  = '0;
    for (int c = 0; c < MAP_WIDTH; c++) begin
      n = 4'(up_w[c])  + 4'(up[c])  + 4'(up_e[c]) +
          4'(mid_w[c]) + 4'(mid_e[c]) +
          4'(dn_w[c])  + 4'(dn[c])  + 4'(dn_e[c]);
      row_next[c] = mid[c] ? survive_lat[n] : birth_lat[n];
      row_pop     = row_pop + POP_W'(row_next[c]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank[0]     <= '0;
      bank[1]     <= '0;
      act         <= 1'b0;
      row         <= '0;
      acc         <= '0;
      wrap_lat    <= 1'b0;
      birth_lat   <= '0;
      survive_lat <= '0;
      generation  <= '0;
      population  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clear) begin
            bank[0]    <= '0;
            bank[1]    <= '0;
            generation <= '0;
            population <= '0;
          end else if (start) begin
            wrap_lat    <= wrap_mode;
            birth_lat   <= birth_mask;
            survive_lat <= survive_mask;
            row         <= '0;
            acc         <= '0;
          end else if (wr_hit) begin
            bank[act][wAddrR[ROW_W-1:0]][wAddrC[COL_W-1:0]] <= write_data;
            if (write_data && !cell_old) begin
              population <= population + 1'b1;
            end else if (!write_data && cell_old) begin
              population <= population - 1'b1;
            end
          end
        end
        EVOLVE: begin
          bank[~act][row] <= row_next;
          acc             <= acc + row_pop;
          row             <= row + 1'b1;
          // Last row lands in the shadow bank on the same edge the banks swap.
          if (row == LAST_ROW) begin
            act        <= ~act;
            generation <= generation + 1'b1;
            population <= acc + row_pop;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      read_data <= 1'b0;
    end else begin
      read_data <= rd_hit ? bank[act][rAddrR[ROW_W-1:0]][rAddrC[COL_W-1:0]] : 1'b0;
    end
  end

endmodule
